// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the IFU/LSU memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU, LSU and memory-side signals of the arbiter
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [ADDR_WIDTH-1:0]   ifu_addr;
  logic                    lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_wen;
  logic [ADDR_WIDTH-1:0]   lsu_addr;
  logic [DATA_WIDTH-1:0]   lsu_wdata, rdata;
  logic [DATA_WIDTH/8-1:0] lsu_wmask;
  logic                    mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata, mem_rdata;
  logic [DATA_WIDTH/8-1:0] mem_wmask;
  modport slave (
    input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid, rdata,
           mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
  modport master (
    output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
           mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid, rdata,
           mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter_rr_grant2.sv
// rr_grant2: two-way round-robin picker, bit 0 = IFU, bit 1 = LSU, one-hot grant
module rr_grant2 import mem_arbiter_pkg::*; (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);
  always_comb o_grant = (&i_req) ? ((i_last == M_IFU) ? 2'b10 : 2'b01) : i_req;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU and LSU, one transaction outstanding,
// round-robin on conflict, response routed back to the issuing master
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  state_t                  r_state;
  logic                    r_last, r_owner, r_mem_req_valid, r_mem_wen, r_ifu_resp, r_lsu_resp;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata, r_rdata;
  logic [DATA_WIDTH/8-1:0] r_mem_wmask;
  logic [1:0]              w_grant;
  logic                    w_idle, w_hs_ifu, w_hs_lsu;

  rr_grant2 u_rr (
    .i_req   ({bus.lsu_req_valid, bus.ifu_req_valid}),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_idle             = r_state == S_IDLE;
  assign w_hs_ifu           = w_idle & w_grant[M_IFU];
  assign w_hs_lsu           = w_idle & w_grant[M_LSU];
  assign bus.ifu_req_ready  = w_hs_ifu;
  assign bus.lsu_req_ready  = w_hs_lsu;
  assign bus.ifu_resp_valid = r_ifu_resp;
  assign bus.lsu_resp_valid = r_lsu_resp;
  assign bus.rdata          = r_rdata;
  assign bus.mem_req_valid  = r_mem_req_valid;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wen        = r_mem_wen;
  assign bus.mem_wdata      = r_mem_wdata;
  assign bus.mem_wmask      = r_mem_wmask;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_last          <= M_IFU;
      r_owner         <= M_IFU;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_wen       <= 1'b0;
      r_mem_wdata     <= '0;
      r_mem_wmask     <= '0;
      r_ifu_resp      <= 1'b0;
      r_lsu_resp      <= 1'b0;
      r_rdata         <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_hs_ifu | w_hs_lsu) begin
          r_state         <= S_REQ;
          r_mem_req_valid <= 1'b1;
          r_owner         <= w_hs_lsu;
          r_last          <= w_hs_lsu;
          r_mem_addr      <= w_hs_lsu ? bus.lsu_addr : bus.ifu_addr;
          r_mem_wen       <= w_hs_lsu & bus.lsu_wen;
          r_mem_wdata     <= w_hs_lsu ? bus.lsu_wdata : '0;
          r_mem_wmask     <= w_hs_lsu ? bus.lsu_wmask : '0;
        end
        S_REQ: if (bus.mem_req_ready) begin
          r_state         <= S_WAIT;
          r_mem_req_valid <= 1'b0;
        end
        // write acks capture mem_rdata too; masters ignore it
        S_WAIT: if (bus.mem_resp_valid) begin
          r_state    <= S_RESP;
          r_rdata    <= bus.mem_rdata;
          r_ifu_resp <= r_owner == M_IFU;
          r_lsu_resp <= r_owner == M_LSU;
        end
        S_RESP: begin
          r_state    <= S_IDLE;
          r_ifu_resp <= 1'b0;
          r_lsu_resp <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random masters and memory against a timestamp-based reference model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int DW = 32;
  localparam int AW = 32;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  logic          ifu_v = 0, lsu_v = 0, lsu_we = 0, mrdy = 0, mrv = 0;
  logic [AW-1:0] ifu_a = '0, lsu_a = '0;
  logic [DW-1:0] lsu_wd = '0, mrd = '0;
  logic [3:0]    lsu_wm = '0;
  int p_req = 40, p_drop = 10, p_rdy = 70, p_spur = 20, lat_min = 1, lat_max = 3;
  bit hold = 0, rand_rd = 1;

  bit            act = 0;
  int            acc = -1, mr = -1, due = -1;
  logic          own = M_IFU, last = M_IFU;
  logic [AW-1:0] e_addr;
  logic          e_wen;
  logic [DW-1:0] e_wd, e_rdata = '0;
  logic [3:0]    e_wm;
  int            order[$];

  task automatic drive();
    bus.ifu_req_valid  = ifu_v;
    bus.ifu_addr       = ifu_a;
    bus.lsu_req_valid  = lsu_v;
    bus.lsu_addr       = lsu_a;
    bus.lsu_wen        = lsu_we;
    bus.lsu_wdata      = lsu_wd;
    bus.lsu_wmask      = lsu_wm;
    bus.mem_req_ready  = mrdy;
    bus.mem_resp_valid = mrv;
    bus.mem_rdata      = mrd;
  endtask

  task automatic new_ifu();
    ifu_v = 1; ifu_a = $urandom;
  endtask

  task automatic new_lsu();
    lsu_v = 1; lsu_a = $urandom; lsu_we = $urandom_range(1); lsu_wd = $urandom; lsu_wm = 4'($urandom);
  endtask

  // picks the inputs of the upcoming cycle; a genuine response only lands on its due cycle
  task automatic gen();
    int c = cyc + 1;
    if (hold) begin
      if (!ifu_v) new_ifu();
      if (!lsu_v) new_lsu();
    end else begin
      if (ifu_v) begin if ($urandom_range(99) < p_drop) ifu_v = 0; end
      else if ($urandom_range(99) < p_req) new_ifu();
      if (lsu_v) begin if ($urandom_range(99) < p_drop) lsu_v = 0; end
      else if ($urandom_range(99) < p_req) new_lsu();
    end
    mrdy = $urandom_range(99) < p_rdy;
    mrd  = rand_rd ? DW'($urandom) : 32'h0000_0297;
    mrv  = (due >= 0) ? (c == due) : ($urandom_range(99) < p_spur);
  endtask

  task automatic model();
    logic ei, el, ri, rl, mv;
    int c = cyc;
    ei = 0; el = 0;
    if (!act) begin
      if (ifu_v && lsu_v) begin ei = (last == M_LSU); el = !ei; end
      else begin ei = ifu_v; el = lsu_v; end
    end
    if (bus.ifu_req_valid && bus.ifu_req_ready) order.push_back(0);
    if (bus.lsu_req_valid && bus.lsu_req_ready) order.push_back(1);
    ri = act && mr >= 0 && c == mr + 1 && own == M_IFU;
    rl = act && mr >= 0 && c == mr + 1 && own == M_LSU;
    mv = act && acc < 0;
    check("ifu_req_ready", bus.ifu_req_ready, ei);
    check("lsu_req_ready", bus.lsu_req_ready, el);
    check("ifu_resp_valid", bus.ifu_resp_valid, ri);
    check("lsu_resp_valid", bus.lsu_resp_valid, rl);
    check("rdata", bus.rdata, e_rdata);
    check("mem_req_valid", bus.mem_req_valid, mv);
    if (mv) begin
      check("mem_addr", bus.mem_addr, e_addr);
      check("mem_wen", bus.mem_wen, e_wen);
      check("mem_wmask", bus.mem_wmask, e_wm);
      if (e_wen) check("mem_wdata", bus.mem_wdata, e_wd);
    end
    if (act) begin
      if (acc < 0 && mrdy) begin acc = c; due = c + $urandom_range(lat_max, lat_min); end
      else if (acc >= 0 && mr < 0 && mrv) begin mr = c; due = -1; e_rdata = mrd; end
      else if (mr >= 0 && c == mr + 1) act = 0;
    end else if (ei || el) begin
      act = 1; acc = -1; mr = -1; own = el; last = el;
      e_addr = el ? lsu_a : ifu_a;
      e_wen  = el & lsu_we;
      e_wd   = lsu_wd;
      e_wm   = el ? lsu_wm : 4'b0;
      if (el) lsu_v = 0; else ifu_v = 0;
    end
  endtask

  task automatic tick(input bit en);
    @(posedge clk);
    cyc++;
    #1 drive();
    @(negedge clk);
    if (en) model();
  endtask

  task automatic run(input int n);
    repeat (n) begin gen(); tick(1); end
  endtask

  // late/stale memory responses are driven during reset; none may surface
  task automatic do_reset(input int n);
    rst = 0; ifu_v = 0; lsu_v = 0; mrv = 1; mrdy = 1; due = -1;
    repeat (n) tick(0);
    check("rst_mem_req_valid", bus.mem_req_valid, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wen", bus.mem_wen, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_wmask", bus.mem_wmask, 0);
    check("rst_ifu_resp", bus.ifu_resp_valid, 0);
    check("rst_lsu_resp", bus.lsu_resp_valid, 0);
    check("rst_rdata", bus.rdata, 0);
    rst = 1; act = 0; last = M_IFU; e_rdata = '0; mrv = 0;
  endtask

  initial begin
    do_reset(3);
    // single IFU read, memory always ready, 1-cycle response
    p_req = 0; p_drop = 0; p_rdy = 100; p_spur = 0; lat_min = 1; lat_max = 1; rand_rd = 0;
    ifu_v = 1; ifu_a = RESET_PC;
    run(6);
    check("ifu_read_rdata", bus.rdata, 32'h0000_0297);
    // LSU write under 5 cycles of backpressure
    rand_rd = 1; p_rdy = 0;
    lsu_v = 1; lsu_a = 32'h8000_0100; lsu_we = 1; lsu_wd = 32'hDEAD_BEEF; lsu_wm = 4'b0011;
    run(6);
    check("bp_still_req", bus.mem_req_valid, 1);
    p_rdy = 100; lat_max = 2;
    run(6);
    // simultaneous requests straight after reset
    do_reset(1);
    order.delete();
    hold = 1;
    run(20);
    hold = 0; ifu_v = 0; lsu_v = 0;
    run(8);
    check("grant0", order.size() > 0 ? order[0] : 9, 1);
    check("grant1", order.size() > 1 ? order[1] : 9, 0);
    check("grant2", order.size() > 2 ? order[2] : 9, 1);
    // reset while waiting for the memory response
    lat_min = 8; lat_max = 8;
    ifu_v = 1; ifu_a = 32'h8000_0040;
    for (int i = 0; i < 20 && !(act && acc >= 0); i++) run(1);
    check("reached_wait", act && acc >= 0 && mr < 0, 1);
    do_reset(1);
    p_spur = 100;
    run(4);
    // random traffic
    p_req = 40; p_drop = 10; p_rdy = 70; p_spur = 20; lat_min = 1; lat_max = 3;
    run(3000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
